// File: rtl/branch_resolve_stage_pkg.sv
// Shared encodings for the branch resolve stage: func3 branch codes, ALU compare-flag
// bit positions and the redirect FSM state type.
package branch_resolve_stage_pkg;

    localparam logic [2:0] Func3Beq  = 3'd0;
    localparam logic [2:0] Func3Bne  = 3'd1;
    localparam logic [2:0] Func3Blt  = 3'd4;
    localparam logic [2:0] Func3Bge  = 3'd5;
    localparam logic [2:0] Func3Bltu = 3'd6;
    localparam logic [2:0] Func3Bgeu = 3'd7;

    // Bit positions inside the ALU compare vector {ltu, lt, eq}.
    localparam int unsigned CmpEq  = 0;
    localparam int unsigned CmpLt  = 1;
    localparam int unsigned CmpLtu = 2;

    typedef enum logic [0:0] {
        StIdle,
        StRedirect
    } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational taken decision for conditional branches and unconditional jumps.
module branch_cond
    import branch_resolve_stage_pkg::*;
(
    input  logic [2:0] func3,
    input  logic [2:0] compare,
    input  logic       is_branch,
    input  logic       is_jal,
    input  logic       is_jalr,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        if (is_branch) begin
            case (func3)
                Func3Beq:  taken = compare[CmpEq];
                Func3Bne:  taken = !compare[CmpEq];
                Func3Blt:  taken = compare[CmpLt];
                Func3Bge:  taken = !compare[CmpLt];
                Func3Bltu: taken = compare[CmpLtu];
                Func3Bgeu: taken = !compare[CmpLtu];
                default:   taken = 1'b0;
            endcase
        end else begin
            taken = is_jal || is_jalr;
        end
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-to-memory stage: registers the ALU payload, resolves branches/jumps against the
// fetch prediction and holds a redirect request until fetch takes it.
module branch_resolve_stage
    import branch_resolve_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_func3,
    input  logic             in_is_branch,
    input  logic             in_is_jal,
    input  logic             in_is_jalr,
    input  logic             in_regwrite,
    input  logic [4:0]       in_rd,
    input  logic [XLEN-1:0]  in_result,
    input  logic [2:0]       in_compare,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_count
);

    state_e            state_q, state_d;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_pc_q, out_result_q, redirect_pc_q;
    logic [4:0]        out_rd_q;
    logic              out_regwrite_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              taken, mispredict, accept;
    logic [XLEN-1:0]   pc_plus4, target, correct_pc;

    branch_cond u_branch_cond (
        .func3     (in_func3),
        .compare   (in_compare),
        .is_branch (in_is_branch),
        .is_jal    (in_is_jal),
        .is_jalr   (in_is_jalr),
        .taken     (taken)
    );

    assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign pc_plus4   = in_pc + XLEN'(4);
    // JALR drops bit 0 only; a set bit 1 is passed through unchanged.
    assign target     = in_is_jalr ? {in_result[XLEN-1:1], 1'b0} : in_pc + in_imm;
    assign correct_pc = taken ? target : pc_plus4;
    assign mispredict = (in_is_branch && (taken != in_pred_taken))
                     || (in_is_jal && !in_pred_taken)
                     || in_is_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_regwrite_q <= 1'b0;
        end else if (accept) begin
            out_valid_q    <= 1'b1;
            out_pc_q       <= in_pc;
            out_result_q   <= (in_is_jal || in_is_jalr) ? pc_plus4 : in_result;
            out_rd_q       <= in_rd;
            out_regwrite_q <= in_regwrite && !in_is_branch;
        end else if (out_ready) begin
            out_valid_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept && mispredict) state_d = StRedirect;
            StRedirect: if (redirect_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q <= state_d;
            if (accept && mispredict) begin
                redirect_pc_q <= correct_pc;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_pc           = out_pc_q;
    assign out_result       = out_result_q;
    assign out_rd           = out_rd_q;
    assign out_regwrite     = out_regwrite_q;
    assign redirect_valid   = (state_q == StRedirect);
    assign redirect_pc      = redirect_pc_q;
    assign flush            = redirect_valid;
    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage: vector table feeding an output/redirect
// scoreboard, plus hand sequences for redirect hold, backpressure, reset and saturation.
module tb_branch_resolve_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_is_branch, in_is_jal, in_is_jalr, in_regwrite, in_pred_taken;
    logic [31:0] in_pc, in_imm, in_result;
    logic [2:0]  in_func3, in_compare;
    logic [4:0]  in_rd;
    logic        out_ready, redirect_ready;

    logic        in_ready, out_valid, out_regwrite, redirect_valid, flush;
    logic [31:0] out_pc, out_result, redirect_pc;
    logic [4:0]  out_rd;
    logic [15:0] mispredict_count;

    logic        s_in_ready, s_out_valid, s_out_regwrite, s_redirect_valid, s_flush;
    logic [31:0] s_out_pc, s_out_result, s_redirect_pc;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_count;

    always #5 clk = ~clk;

    branch_resolve_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_imm(in_imm), .in_func3(in_func3), .in_is_branch(in_is_branch),
        .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_result(in_result), .in_compare(in_compare),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
        .mispredict_count(mispredict_count)
    );

    branch_resolve_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
        .in_imm(in_imm), .in_func3(in_func3), .in_is_branch(in_is_branch),
        .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_result(in_result), .in_compare(in_compare),
        .in_pred_taken(in_pred_taken), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_result(s_out_result), .out_rd(s_out_rd),
        .out_regwrite(s_out_regwrite), .redirect_valid(s_redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(s_redirect_pc), .flush(s_flush),
        .mispredict_count(s_count)
    );

    typedef struct {
        logic [31:0] pc, imm, res;
        logic [2:0]  f3, cmp;
        logic        br, jal, jalr, rw, pred;
        logic [4:0]  rd;
        logic        mis;
        logic [31:0] rpc, wres;
        logic        wrw;
    } vec_t;

    vec_t        vecs[14];
    vec_t        outq[$];
    logic [31:0] rdq[$];
    int          cur = 0;
    int          tests = 0;
    int          fails = 0;

    function automatic vec_t mk(input logic [31:0] pc, imm, res, input logic [2:0] f3, cmp,
                                input logic br, jal, jalr, rw, pred, input logic [4:0] rd,
                                input logic mis, input logic [31:0] rpc, wres,
                                input logic wrw);
        vec_t v;
        v.pc = pc; v.imm = imm; v.res = res; v.f3 = f3; v.cmp = cmp;
        v.br = br; v.jal = jal; v.jalr = jalr; v.rw = rw; v.pred = pred; v.rd = rd;
        v.mis = mis; v.rpc = rpc; v.wres = wres; v.wrw = wrw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pops are done before pushes so a same-cycle drain+accept stays ordered.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (outq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    vec_t e;
                    e = outq.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_result", out_result, e.wres);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_regwrite", out_regwrite, e.wrw);
                    chk("sat_out_payload", {s_out_valid, s_out_pc, s_out_result, s_out_rd,
                        s_out_regwrite}, {1'b1, e.pc, e.wres, e.rd, e.wrw});
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_redirect", 1, 0);
                end else begin
                    logic [31:0] r;
                    r = rdq.pop_front();
                    chk("redirect_pc", redirect_pc, r);
                    chk("sat_redirect", {s_redirect_valid, s_redirect_pc}, {1'b1, r});
                    chk("handshake_flush_ready", {flush, s_flush, in_ready, s_in_ready},
                        4'b1100);
                end
            end
            if (in_valid && in_ready) begin
                outq.push_back(vecs[cur]);
                if (vecs[cur].mis) rdq.push_back(vecs[cur].rpc);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input int idx);
        bit ok = 0;
        cur           = idx;
        in_valid      = 1'b1;
        in_pc         = vecs[idx].pc;
        in_imm        = vecs[idx].imm;
        in_result     = vecs[idx].res;
        in_func3      = vecs[idx].f3;
        in_compare    = vecs[idx].cmp;
        in_is_branch  = vecs[idx].br;
        in_is_jal     = vecs[idx].jal;
        in_is_jalr    = vecs[idx].jalr;
        in_regwrite   = vecs[idx].rw;
        in_pred_taken = vecs[idx].pred;
        in_rd         = vecs[idx].rd;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            out_ready      = 1'b1;
            redirect_ready = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        //               pc            imm           res           f3    cmp     br jal jr rw pr rd   mis rpc           wres          wrw
        vecs[0]  = mk(32'h100,      32'h20,       32'h55,       3'd0, 3'b001, 1, 0, 0, 1, 0, 5'd5, 1, 32'h120,      32'h55,       0);
        vecs[1]  = mk(32'h300,      32'h40,       32'h11,       3'd6, 3'b100, 1, 0, 0, 1, 1, 5'd3, 0, 32'h0,        32'h11,       0);
        vecs[2]  = mk(32'h200,      32'h80,       32'h22,       3'd5, 3'b010, 1, 0, 0, 0, 1, 5'd4, 1, 32'h204,      32'h22,       0);
        vecs[3]  = mk(32'h400,      32'h0,        32'h3001,     3'd0, 3'b000, 0, 0, 1, 1, 1, 5'd1, 1, 32'h3000,     32'h404,      1);
        vecs[4]  = mk(32'h500,      32'hFFFFFFF0, 32'h99,       3'd0, 3'b000, 0, 1, 0, 1, 0, 5'd2, 1, 32'h4F0,      32'h504,      1);
        vecs[5]  = mk(32'h600,      32'h100,      32'h0,        3'd0, 3'b000, 0, 1, 0, 1, 1, 5'd3, 0, 32'h0,        32'h604,      1);
        vecs[6]  = mk(32'h700,      32'h10,       32'h7,        3'd1, 3'b001, 1, 0, 0, 0, 0, 5'd0, 0, 32'h0,        32'h7,        0);
        vecs[7]  = mk(32'h800,      32'h10,       32'h8,        3'd1, 3'b000, 1, 0, 0, 0, 0, 5'd0, 1, 32'h810,      32'h8,        0);
        vecs[8]  = mk(32'h900,      32'h30,       32'h9,        3'd4, 3'b010, 1, 0, 0, 0, 1, 5'd0, 0, 32'h0,        32'h9,        0);
        vecs[9]  = mk(32'hA00,      32'h8,        32'hA,        3'd7, 3'b000, 1, 0, 0, 0, 0, 5'd0, 1, 32'hA08,      32'hA,        0);
        vecs[10] = mk(32'hB00,      32'h10,       32'hB,        3'd2, 3'b111, 1, 0, 0, 0, 1, 5'd0, 1, 32'hB04,      32'hB,        0);
        vecs[11] = mk(32'hC00,      32'h40,       32'hDEADBEEF, 3'd0, 3'b001, 0, 0, 0, 1, 0, 5'd7, 0, 32'h0,        32'hDEADBEEF, 1);
        vecs[12] = mk(32'hFFFFFFF0, 32'h20,       32'h0,        3'd0, 3'b000, 0, 1, 0, 1, 0, 5'd8, 1, 32'h10,       32'hFFFFFFF4, 1);
        vecs[13] = mk(32'h100,      32'h2,        32'hD,        3'd0, 3'b001, 1, 0, 0, 1, 0, 5'd9, 1, 32'h102,      32'hD,        0);

        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_imm = '0; in_result = '0;
        in_func3 = '0; in_compare = '0; in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0;
        in_regwrite = 0; in_pred_taken = 0; in_rd = '0; out_ready = 1'b1;
        redirect_ready = 1'b0;
        repeat (3) cycle();
        chk("reset_outputs", {out_valid, out_pc, out_result, out_rd, out_regwrite,
            redirect_valid, redirect_pc, flush, mispredict_count}, '0);
        rst_n = 1'b1;
        cycle();
        chk("reset_in_ready", in_ready, 1);

        // Mispredicted BEQ with fetch holding off the redirect.
        send(0);
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_flush", flush, 1);
        chk("beq_out_regwrite", out_regwrite, 0);
        chk("beq_in_ready", in_ready, 0);
        chk("beq_count", mispredict_count, 1);
        repeat (3) cycle();
        chk("redirect_hold", {redirect_valid, redirect_pc, in_ready}, {1'b1, 32'h120, 1'b0});
        redirect_ready = 1'b1;
        cycle();
        chk("redirect_release", {redirect_valid, flush, in_ready}, 3'b001);
        chk("beq_count_after", mispredict_count, 1);

        // Backpressure: payload holds, then drain and accept in the same cycle.
        out_ready = 1'b0;
        send(1);
        chk("bltu_no_redirect", redirect_valid, 0);
        chk("bltu_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", {out_valid, out_pc, out_result, in_ready},
                {1'b1, 32'h300, 32'h11, 1'b0});
        end
        out_ready = 1'b1;
        send(5);
        chk("bp_new_payload", {out_valid, out_pc, out_result}, {1'b1, 32'h600, 32'h604});

        foreach (vecs[i]) begin
            if (i >= 2 && i != 5) begin
                out_ready      = 1'($urandom_range(0, 1));
                redirect_ready = 1'($urandom_range(0, 1));
                send(i);
            end
        end
        out_ready = 1'b1; redirect_ready = 1'b1;
        for (int c = 0; c < 50 && (outq.size() != 0 || rdq.size() != 0); c++) cycle();
        chk("scoreboard_drained", {32'(outq.size()), 32'(rdq.size())}, 0);
        chk("count_total", mispredict_count, 9);
        chk("count_saturated", s_count, 3);

        // Reset while a redirect is pending.
        redirect_ready = 1'b0;
        send(7);
        chk("pre_reset_redirect", redirect_valid, 1);
        #2 rst_n = 1'b0;
        outq.delete(); rdq.delete();
        #1;
        chk("async_reset_outputs", {out_valid, out_pc, out_result, out_rd, out_regwrite,
            redirect_valid, redirect_pc, flush, mispredict_count}, '0);
        chk("async_reset_sat", {s_out_valid, s_redirect_valid, s_flush, s_count}, '0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_reset_in_ready", {in_ready, redirect_valid}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
